// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the two-requester mux arbiter.
package mux2_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGntA = 2'd1,
    StGntB = 2'd2
  } arb_state_e;

  localparam logic SelA = 1'b0;
  localparam logic SelB = 1'b1;

endpackage

// File: rtl/mux2t1_w.sv
// WIDTH-bit combinational 2-to-1 multiplexer.
module mux2t1_w #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin owner of a shared 2-to-1 mux, with burst-limited grants and a
// single registered valid/ready output stage.
module mux2_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] a,
  output logic             ack_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] b,
  output logic             ack_b,
  output logic [WIDTH-1:0] o,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             sel
);

  localparam int unsigned CntW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BURST - 1);

  arb_state_e      state_q, state_d;
  logic            last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] o_q;
  logic            o_valid_q, sel_q;
  logic            space, mux_sel;
  logic [WIDTH-1:0] mux_y;

  assign space   = !o_valid_q || o_ready;
  assign mux_sel = (state_q == StGntB) ? SelB : SelA;
  assign ack_a   = (state_q == StGntA) && req_a && space;
  assign ack_b   = (state_q == StGntB) && req_b && space;

  mux2t1_w #(
    .WIDTH(WIDTH)
  ) u_mux (
    .a  (a),
    .b  (b),
    .sel(mux_sel),
    .y  (mux_y)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        // On a tie, the side not served last wins.
        if (req_a && (!req_b || last_q == SelB)) begin
          state_d = StGntA;
          last_d  = SelA;
          cnt_d   = '0;
        end else if (req_b) begin
          state_d = StGntB;
          last_d  = SelB;
          cnt_d   = '0;
        end
      end
      StGntA: begin
        if (!req_a) begin
          state_d = req_b ? StGntB : StIdle;
          cnt_d   = '0;
          if (req_b) last_d = SelB;
        end else if (ack_a) begin
          if (cnt_q == CntMax) begin
            cnt_d = '0;
            if (req_b) begin
              state_d = StGntB;
              last_d  = SelB;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StGntB: begin
        if (!req_b) begin
          state_d = req_a ? StGntA : StIdle;
          cnt_d   = '0;
          if (req_a) last_d = SelA;
        end else if (ack_b) begin
          if (cnt_q == CntMax) begin
            cnt_d = '0;
            if (req_a) begin
              state_d = StGntA;
              last_d  = SelA;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      last_q    <= SelB;
      cnt_q     <= '0;
      o_q       <= '0;
      o_valid_q <= 1'b0;
      sel_q     <= SelA;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      // A fill in the same cycle as a drain keeps o_valid high.
      if (ack_a || ack_b) begin
        o_q       <= mux_y;
        sel_q     <= mux_sel;
        o_valid_q <= 1'b1;
      end else if (o_valid_q && o_ready) begin
        o_valid_q <= 1'b0;
      end
    end
  end

  assign o       = o_q;
  assign o_valid = o_valid_q;
  assign sel     = sel_q;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed bench for mux2_arbiter: per-cycle behavioural model plus literal checks.
module tb_mux2_arbiter;

  localparam int unsigned W = 4;
  localparam int unsigned B = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_a = 1'b0, req_b = 1'b0, o_ready = 1'b1;
  logic [W-1:0] a = '0, b = '0;
  logic         ack_a, ack_b, o_valid, sel;
  logic [W-1:0] o;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  mux2_arbiter #(
    .WIDTH(W),
    .BURST(B)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req_a  (req_a),
    .a      (a),
    .ack_a  (ack_a),
    .req_b  (req_b),
    .b      (b),
    .ack_b  (ack_b),
    .o      (o),
    .o_valid(o_valid),
    .o_ready(o_ready),
    .sel    (sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: owner -1 = none, 0 = A, 1 = B; beats counts accepted beats in this grant.
  int           m_owner = -1;
  int           m_last  = 1;
  int           m_beats = 0;
  logic [W-1:0] m_o     = '0;
  bit           m_valid = 1'b0;
  bit           m_sel   = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      bit space, e_ack_a, e_ack_b, mine, other;
      space   = !m_valid || o_ready;
      e_ack_a = (m_owner == 0) && req_a && space;
      e_ack_b = (m_owner == 1) && req_b && space;
      check("model_ack_a", 32'(ack_a), 32'(e_ack_a));
      check("model_ack_b", 32'(ack_b), 32'(e_ack_b));
      check("model_o_valid", 32'(o_valid), 32'(m_valid));
      check("model_o", 32'(o), 32'(m_o));
      check("model_sel", 32'(sel), 32'(m_sel));
      if (rst) begin
        m_owner = -1; m_last = 1; m_beats = 0;
        m_o = '0; m_valid = 1'b0; m_sel = 1'b0;
      end else begin
        if (e_ack_a || e_ack_b) begin
          m_o = e_ack_a ? a : b;
          m_sel = e_ack_b;
          m_valid = 1'b1;
        end else if (m_valid && o_ready) begin
          m_valid = 1'b0;
        end
        if (m_owner < 0) begin
          if (req_a && req_b) m_owner = 1 - m_last;
          else if (req_a) m_owner = 0;
          else if (req_b) m_owner = 1;
          if (m_owner >= 0) begin
            m_last = m_owner; m_beats = 0;
          end
        end else begin
          mine  = (m_owner == 0) ? req_a : req_b;
          other = (m_owner == 0) ? req_b : req_a;
          if (!mine) begin
            m_owner = other ? 1 - m_owner : -1;
            if (other) m_last = m_owner;
            m_beats = 0;
          end else if (e_ack_a || e_ack_b) begin
            m_beats++;
            if (m_beats == B) begin
              m_beats = 0;
              if (other) begin
                m_owner = 1 - m_owner; m_last = m_owner;
              end
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; o_ready = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Phase 1: reset, no requests
    do_reset();
    chk_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      mid();
      check("idle_o", 32'(o), 32'h0);
      check("idle_valid", 32'(o_valid), 32'h0);
      check("idle_sel", 32'(sel), 32'h0);
      check("idle_acks", 32'({ack_a, ack_b}), 32'h0);
      step();
    end

    // Phase 2: single requester A
    a = 4'b1010; req_a = 1'b1;
    mid(); check("a_ack_c0", 32'(ack_a), 32'h0); step();
    mid(); check("a_ack_c1", 32'(ack_a), 32'h1); step();
    for (int k = 2; k < 6; k++) begin
      mid();
      check("a_o", 32'(o), 32'hA);
      check("a_valid", 32'(o_valid), 32'h1);
      check("a_sel", 32'(sel), 32'h0);
      check("a_no_ack_b", 32'(ack_b), 32'h0);
      step();
    end
    req_a = 1'b0;
    step(); step();

    // Phase 3: both requesting, 4+4 burst alternation without bubbles
    do_reset();
    a = 4'b1010; b = 4'b0001; req_a = 1'b1; req_b = 1'b1;
    for (int k = 0; k < 18; k++) begin
      mid();
      if (k >= 2) begin
        bit src_b;
        src_b = (((k - 2) / 4) % 2) == 1;
        check("rr_valid", 32'(o_valid), 32'h1);
        check("rr_o", 32'(o), src_b ? 32'h1 : 32'hA);
        check("rr_sel", 32'(sel), 32'(src_b));
      end
      step();
    end

    // Phase 4: backpressure freezes the burst, then A finishes its 2 remaining beats
    do_reset();
    a = 4'b0110; b = 4'b0011; req_a = 1'b1; req_b = 1'b0;
    mid(); step();
    mid(); check("bp_ack_c1", 32'(ack_a), 32'h1); step();
    mid(); check("bp_ack_c2", 32'(ack_a), 32'h1); step();
    o_ready = 1'b0; req_b = 1'b1;
    for (int k = 0; k < 5; k++) begin
      mid();
      check("bp_frozen_acks", 32'({ack_a, ack_b}), 32'h0);
      check("bp_frozen_o", 32'(o), 32'h6);
      check("bp_frozen_sel", 32'(sel), 32'h0);
      check("bp_frozen_valid", 32'(o_valid), 32'h1);
      step();
    end
    o_ready = 1'b1;
    mid(); check("bp_rel_ack_a1", 32'(ack_a), 32'h1); step();
    mid(); check("bp_rel_ack_a2", 32'(ack_a), 32'h1); step();
    mid();
    check("bp_switch_ack_b", 32'(ack_b), 32'h1);
    check("bp_switch_ack_a", 32'(ack_a), 32'h0);
    step();

    // Phase 5: A drops after 2 beats; B gets a full burst
    do_reset();
    a = 4'b1100; b = 4'b0101; req_a = 1'b1; req_b = 1'b1;
    mid(); step();
    mid(); check("drop_ack_a1", 32'(ack_a), 32'h1); step();
    mid(); check("drop_ack_a2", 32'(ack_a), 32'h1); step();
    req_a = 1'b0;
    mid(); check("drop_gap_acks", 32'({ack_a, ack_b}), 32'h0); step();
    for (int k = 4; k < 7; k++) begin
      mid(); check("drop_b_burst", 32'(ack_b), 32'h1); step();
    end
    req_a = 1'b1;
    mid();
    check("drop_b_last", 32'(ack_b), 32'h1);
    check("drop_b_last_no_a", 32'(ack_a), 32'h0);
    step();
    mid();
    check("drop_back_a", 32'(ack_a), 32'h1);
    check("drop_back_no_b", 32'(ack_b), 32'h0);
    check("drop_o_b", 32'(o), 32'h5);
    check("drop_sel_b", 32'(sel), 32'h1);
    step();

    // Phase 6: reset mid-burst with a pending beat
    mid(); check("rst_pre_valid", 32'(o_valid), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    mid();
    check("rst_o", 32'(o), 32'h0);
    check("rst_valid", 32'(o_valid), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_acks", 32'({ack_a, ack_b}), 32'h0);
    step();
    mid();
    check("rst_tie_a", 32'(ack_a), 32'h1);
    check("rst_tie_no_b", 32'(ack_b), 32'h0);
    step();

    req_a = 1'b0; req_b = 1'b0;
    step(); step(); step();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux2_arbiter.md
# mux2_arbiter

Round-robin arbiter and output stage that shares one WIDTH-bit 2-to-1 multiplexer between two requesters, A and B. It owns the mux select, grants one requester at a time, and forwards accepted data through a single registered valid/ready output stage. Ownership is held for bursts of up to BURST beats. It sits between two producer blocks and any single consumer of the muxed bus.

## Interface
- WIDTH, 4: data width of a, b, o.
- BURST, 4: maximum beats per grant while the other side is requesting (≥1).
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_a  in  1  A has valid data on a; held with a stable until ack_a.
- a  in  WIDTH  A data.
- ack_a  out  1  A beat accepted this cycle (combinational).
- req_b / b / ack_b: same as A, for requester B.
- o  out  WIDTH  registered output data.
- o_valid  out  1  o holds an unconsumed beat.
- o_ready  in  1  consumer takes o this cycle when o_valid=1.
- sel  out  1  source of the beat in o: 0=a, 1=b. Registered with o.

## Operation
- States:
  - IDLE: no owner.
  - GNT_A: A owns the mux. Mux select 0.
  - GNT_B: B owns the mux. Mux select 1.
- Internal registers: state; last (last owner, 0=A, 1=B); cnt (beats in current grant, 0..BURST-1).
- space = !o_valid || o_ready.
- ack_a = (state==GNT_A) && req_a && space. ack_b is symmetric.
- On ack_x: o ← mux output, sel ← owner, o_valid ← 1.
- Otherwise, on o_valid && o_ready: o_valid ← 0. o and sel hold.
- IDLE:
  - Only one req → grant it.
  - Both req → grant !last, i.e. the side not served last.
  - Neither → stay in IDLE.
- GNT_A (GNT_B symmetric):
  - req_a=0 → GNT_B if req_b, else IDLE.
  - ack_a and cnt==BURST-1 → GNT_B if req_b; else stay in GNT_A with cnt ← 0.
  - ack_a otherwise → cnt ← cnt+1.
  - No ack, req_a=1 (output stalled) → hold state and cnt.
- On every change of owner: cnt ← 0, last ← new owner.
- A switch A↔B is direct, with no IDLE bubble.
- A requester that drops req without an ack loses its grant, and no beat is taken.

## Timing
- Reset values: state=IDLE, last=1 (A wins the first tie), cnt=0, o=0, o_valid=0, sel=0. Combinationally, ack_a=ack_b=0.
- Latency from IDLE: req at cycle 0 → grant at edge 1 → ack in cycle 1 if space → o_valid=1 in cycle 2.
- Throughput: one beat per cycle while the owner requests and o_ready=1.
- Simultaneous drain and fill (o_valid && o_ready && ack): the new beat overwrites o, and o_valid stays 1.
- o_ready=0 with o_valid=1: no ack, o is stable, and grant and cnt freeze.
- BURST=1: alternate every beat when both sides request.
- rst mid-burst: everything returns to reset values on the next edge. A pending o beat is dropped. Requesters must re-present.
- cnt width: clog2(BURST), minimum 1 bit. No wrap occurs past BURST-1.

## Structure
- Shared package mux2_arb_pkg:
  - state type {IDLE, GNT_A, GNT_B} with a 2-bit encoding;
  - SEL_A=0, SEL_B=1 constants.
- Sub-module mux2t1_w: parameterised WIDTH 2-to-1 combinational mux (a, b, sel → y), driven by the state-derived select.
- The top level contains the FSM, the counter and the output register.

## Test plan
- Reset, then no requests:
  - o=0, o_valid=0, sel=0, ack_a=ack_b=0 for 10 cycles.
- Single requester A:
  - a=4'b1010, req_a held, o_ready=1 → ack_a in cycle 1, o=4'b1010, sel=0, o_valid=1 from cycle 2.
  - ack_b never asserts.
- Both requesting from reset, BURST=4, o_ready=1, a=4'b1010, b=4'b0001:
  - 4 beats of 1010 with sel=0, then 4 beats of 0001 with sel=1, repeating.
  - No bubble at the switch.
- Backpressure:
  - o_ready=0 for 5 cycles during a burst → o, sel and cnt are frozen, no ack.
  - After release, burst continues with remaining count.
- A drops req after 2 beats while B is requesting:
  - grant moves to B next cycle; B gets a full BURST.
- rst asserted mid-burst with o_valid=1:
  - next cycle: all outputs at reset values.
  - next tie goes to A.
